// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared definitions for the async FIFO pointer blocks. Holds the
//           default address width, the derived pointer width and the Gray
//           conversion helpers. Both the write-side and read-side pointer
//           blocks import this package.
// Helpers : bin2gray(), gray2bin() operate on FN_WIDTH bits. Callers
//           zero-extend narrower pointers and cast the result back down.
//           Zero upper bits do not change the low bits of either conversion.
// Revision: 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int ADDR_WIDTH = 4;
  localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
  localparam int FN_WIDTH   = 32;

  function automatic logic [FN_WIDTH-1:0] bin2gray(input logic [FN_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [FN_WIDTH-1:0] gray2bin(input logic [FN_WIDTH-1:0] g);
    logic [FN_WIDTH-1:0] b;
    b[FN_WIDTH-1] = g[FN_WIDTH-1];
    for (int i = FN_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wptr_full_if.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wptr_full_if
// Purpose : Write-domain bundle between the producer/RAM side and the
//           write-pointer/full block.
// Signals : winc           producer write request
//           rptr_gray_sync read pointer (Gray), already synchronized
//           waddr          RAM write address
//           wen            RAM write enable
//           wptr_gray      registered Gray write pointer to the read domain
//           full           registered full flag
//           overflow       sticky write-while-full flag
//           almost_full    registered occupancy threshold flag
// Modports: master - producer / surrounding logic
//           slave  - fifo_wptr_full
// Revision: 1.0 - initial release
// ============================================================================
interface fifo_wptr_full_if #(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH
);
  import fifo_pkg::*;

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic                  winc;
  logic [PTR_W-1:0]      rptr_gray_sync;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  wen;
  logic [PTR_W-1:0]      wptr_gray;
  logic                  full;
  logic                  overflow;
  logic                  almost_full;

  modport master (
    output winc, rptr_gray_sync,
    input  waddr, wen, wptr_gray, full, overflow, almost_full
  );

  modport slave (
    input  winc, rptr_gray_sync,
    output waddr, wen, wptr_gray, full, overflow, almost_full
  );

endinterface
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module  : gray_to_bin
// Purpose : Combinational Gray-to-binary converter, WIDTH bits.
// Ports   : gray_i  in   WIDTH  Gray-coded value
//           bin_o   out  WIDTH  binary equivalent
// Revision: 1.0 - initial release
// ============================================================================
module gray_to_bin
  import fifo_pkg::*;
#(
  parameter int WIDTH = PTR_WIDTH
) (
  input  wire logic [WIDTH-1:0] gray_i,
  output logic      [WIDTH-1:0] bin_o
);

  assign bin_o = WIDTH'(gray2bin(FN_WIDTH'(gray_i)));

endmodule
`default_nettype wire

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
// Module  : fifo_wptr_full
// Purpose : Write-domain pointer and full-flag generator for the async FIFO
//           between the UART and the system side. Keeps the binary write
//           pointer, drives the RAM write address/enable, publishes a
//           registered Gray write pointer and derives full from the
//           synchronized read pointer.
// Ports   : clk      in  write-domain clock
//           reset_n  in  asynchronous active-low reset
//           bus      fifo_wptr_full_if.slave (winc, rptr_gray_sync in;
//                    waddr, wen, wptr_gray, full, overflow, almost_full out)
// Macro   : FIFO_ALMOST_FULL_EN - enables the registered almost_full flag
//           (occupancy >= AFULL_THRESH). Undefined: almost_full tied low.
// Revision: 1.0 - initial release
// ============================================================================
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = fifo_pkg::ADDR_WIDTH,
  parameter int AFULL_THRESH = 14
) (
  input wire logic        clk,
  input wire logic        reset_n,
  fifo_wptr_full_if.slave bus
);
  import fifo_pkg::*;

  localparam int PTR_W = ADDR_WIDTH + 1;

  // The full compare flips the top two Gray bits; the threshold must be
  // reachable by an occupancy of at most one full FIFO.
  if (ADDR_WIDTH < 2 || AFULL_THRESH > (1 << ADDR_WIDTH)) begin : g_param_check
    $error("fifo_wptr_full: ADDR_WIDTH must be >= 2 and AFULL_THRESH <= depth");
  end

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] rptr_wrapped;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             wen;

  // Write enable uses the registered flag, so a write coinciding with a
  // read-pointer advance while full is still rejected that cycle.
  assign wen     = bus.winc & ~full_q;
  assign wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, wen};
  assign wgray_d = PTR_W'(bin2gray(FN_WIDTH'(wbin_d)));

  // In Gray code, "read pointer plus one depth" is the read pointer with the
  // two MSBs inverted; equality means the writer is exactly one lap ahead.
  assign rptr_wrapped = {~bus.rptr_gray_sync[PTR_W-1:PTR_W-2],
                          bus.rptr_gray_sync[PTR_W-3:0]};
  assign full_d = (wgray_d == rptr_wrapped);
  assign ovf_d  = ovf_q | (bus.winc & full_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign bus.wen       = wen;
  assign bus.wptr_gray = wgray_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level;
  logic             afull_q, afull_d;

  gray_to_bin #(
    .WIDTH (PTR_W)
  ) u_gray_to_bin (
    .gray_i (bus.rptr_gray_sync),
    .bin_o  (rbin)
  );

  // Modular difference is the true occupancy while it stays within one lap.
  assign level   = wbin_d - rbin;
  assign afull_d = (level >= PTR_W'(AFULL_THRESH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign bus.almost_full = afull_q;
`else
  assign bus.almost_full = 1'b0;
`endif

endmodule
`default_nettype wire
